// File: rtl/hit_scan_scheduler.sv
// Per-frame bullet/enemy collision scan on one shared comparator, bullet-major, one pair per clk25; frame_start to hit_valid
// is at most 2+BULLET_COUNT*ENEMY_COUNT cycles; no backpressure (frame_start while busy is dropped and flagged); SCORE_COUNTER_EN adds score.
module hit_scan_scheduler #(
    parameter int BULLET_COUNT = 8,
    parameter int ENEMY_COUNT  = 8,
    parameter int BULLET_W     = 8,
    parameter int ENEMY_W      = 32
) (
    input  logic                       clk25,
    input  logic                       rst_n,
    input  logic                       frame_start,
    input  logic [10*BULLET_COUNT-1:0] bullet_x_bus,
    input  logic [10*BULLET_COUNT-1:0] bullet_y_bus,
    input  logic [BULLET_COUNT-1:0]    bullet_active,
    input  logic [10*ENEMY_COUNT-1:0]  enemy_x_bus,
    input  logic [10*ENEMY_COUNT-1:0]  enemy_y_bus,
    input  logic [ENEMY_COUNT-1:0]     enemy_alive,
    output logic [BULLET_COUNT-1:0]    bullet_hit,
    output logic [ENEMY_COUNT-1:0]     enemy_hit,
    output logic                       hit_valid,
    output logic                       busy,
`ifdef SCORE_COUNTER_EN
    output logic [15:0]                score,
`endif
    output logic                       overrun
);
    localparam int BIW = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
    localparam int EIW = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;
    localparam logic [BIW-1:0] B_LAST = BIW'(BULLET_COUNT - 1);
    localparam logic [EIW-1:0] E_LAST = EIW'(ENEMY_COUNT - 1);

    typedef enum logic [1:0] {IDLE, SNAP, SCAN, REPORT} state_t;

    state_t                     state_q, state_d;
    logic [BIW-1:0]             b_q, b_d;
    logic [EIW-1:0]             e_q, e_d;
    logic [10*BULLET_COUNT-1:0] bx_sh_q, bx_sh_d, by_sh_q, by_sh_d;
    logic [BULLET_COUNT-1:0]    ba_sh_q, ba_sh_d;
    logic [10*ENEMY_COUNT-1:0]  ex_sh_q, ex_sh_d, ey_sh_q, ey_sh_d;
    logic [ENEMY_COUNT-1:0]     ea_sh_q, ea_sh_d;
    logic [BULLET_COUNT-1:0]    bhit_q, bhit_d;
    logic [ENEMY_COUNT-1:0]     ehit_q, ehit_d;
    logic                       overrun_q, overrun_d;

    logic [10:0] bx, by, ex, ey;
    logic        pair_hit;

    // Positions widened to 11 bits so box edges past 1023 do not wrap.
    always_comb begin
        bx = {1'b0, bx_sh_q[b_q*10 +: 10]};
        by = {1'b0, by_sh_q[b_q*10 +: 10]};
        ex = {1'b0, ex_sh_q[e_q*10 +: 10]};
        ey = {1'b0, ey_sh_q[e_q*10 +: 10]};
        pair_hit = ba_sh_q[b_q] && ea_sh_q[e_q] && !ehit_q[e_q]
                && (bx < ex + 11'(ENEMY_W))  && (bx + 11'(BULLET_W) > ex)
                && (by < ey + 11'(ENEMY_W))  && (by + 11'(BULLET_W) > ey);
    end

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        e_d       = e_q;
        bx_sh_d   = bx_sh_q;
        by_sh_d   = by_sh_q;
        ba_sh_d   = ba_sh_q;
        ex_sh_d   = ex_sh_q;
        ey_sh_d   = ey_sh_q;
        ea_sh_d   = ea_sh_q;
        bhit_d    = bhit_q;
        ehit_d    = ehit_q;
        overrun_d = overrun_q || (frame_start && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (frame_start) state_d = SNAP;
            end
            SNAP: begin
                bx_sh_d = bullet_x_bus;
                by_sh_d = bullet_y_bus;
                ba_sh_d = bullet_active;
                ex_sh_d = enemy_x_bus;
                ey_sh_d = enemy_y_bus;
                ea_sh_d = enemy_alive;
                bhit_d  = '0;
                ehit_d  = '0;
                b_d     = '0;
                e_d     = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (pair_hit) begin
                    bhit_d[b_q] = 1'b1;
                    ehit_d[e_q] = 1'b1;
                end
                // A hit retires the bullet early; a miss-only bullet runs the full enemy row.
                if (pair_hit || (e_q == E_LAST)) begin
                    e_d = '0;
                    if (b_q == B_LAST) state_d = REPORT;
                    else               b_d     = b_q + 1'b1;
                end else begin
                    e_d = e_q + 1'b1;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            b_q       <= '0;
            e_q       <= '0;
            bx_sh_q   <= '0;
            by_sh_q   <= '0;
            ba_sh_q   <= '0;
            ex_sh_q   <= '0;
            ey_sh_q   <= '0;
            ea_sh_q   <= '0;
            bhit_q    <= '0;
            ehit_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            e_q       <= e_d;
            bx_sh_q   <= bx_sh_d;
            by_sh_q   <= by_sh_d;
            ba_sh_q   <= ba_sh_d;
            ex_sh_q   <= ex_sh_d;
            ey_sh_q   <= ey_sh_d;
            ea_sh_q   <= ea_sh_d;
            bhit_q    <= bhit_d;
            ehit_q    <= ehit_d;
            overrun_q <= overrun_d;
        end
    end

    assign hit_valid  = (state_q == REPORT);
    assign busy       = (state_q != IDLE);
    assign bullet_hit = hit_valid ? bhit_q : '0;
    assign enemy_hit  = hit_valid ? ehit_q : '0;
    assign overrun    = overrun_q;

`ifdef SCORE_COUNTER_EN
    logic [15:0] score_q, score_d;
    logic [16:0] hit_cnt, score_sum;

    always_comb begin
        hit_cnt = '0;
        for (int j = 0; j < ENEMY_COUNT; j++) hit_cnt = hit_cnt + 17'(ehit_q[j]);
        score_sum = {1'b0, score_q} + hit_cnt;
        score_d   = score_q;
        if (state_q == REPORT) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) score_q <= '0;
        else        score_q <= score_d;
    end

    assign score = score_q;
`endif
endmodule

// File: tb/tb_hit_scan_scheduler.sv
// Directed bench for hit_scan_scheduler: table of single-frame vectors plus hand-written multi-cycle sequences.
module tb_hit_scan_scheduler;
    logic        clk25 = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [79:0] bullet_x_bus, bullet_y_bus, enemy_x_bus, enemy_y_bus;
    logic [7:0]  bullet_active, enemy_alive;
    logic [7:0]  bullet_hit, enemy_hit;
    logic        hit_valid, busy, overrun;
`ifdef SCORE_COUNTER_EN
    logic [15:0] score;
`endif

    hit_scan_scheduler dut (
        .clk25         (clk25),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .bullet_x_bus  (bullet_x_bus),
        .bullet_y_bus  (bullet_y_bus),
        .bullet_active (bullet_active),
        .enemy_x_bus   (enemy_x_bus),
        .enemy_y_bus   (enemy_y_bus),
        .enemy_alive   (enemy_alive),
        .bullet_hit    (bullet_hit),
        .enemy_hit     (enemy_hit),
        .hit_valid     (hit_valid),
        .busy          (busy),
`ifdef SCORE_COUNTER_EN
        .score         (score),
`endif
        .overrun       (overrun)
    );

    always #20 clk25 = ~clk25;

    typedef struct {
        logic [79:0] bx, by, ex, ey;
        logic [7:0]  ba, ea;
        logic [7:0]  bh, eh;
        int          lat;
        string       name;
    } vec_t;

    vec_t rows[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.bx = '0; v.by = '0; v.ex = '0; v.ey = '0;
        v.ba = '0; v.ea = '0; v.bh = '0; v.eh = '0;
        v.lat = 0; v.name = "";
        return v;
    endfunction

    function automatic vec_t set_b(input vec_t vi, input int i, input int x, input int y);
        vec_t v = vi;
        v.bx[i*10 +: 10] = 10'(x);
        v.by[i*10 +: 10] = 10'(y);
        v.ba[i] = 1'b1;
        return v;
    endfunction

    function automatic vec_t set_e(input vec_t vi, input int j, input int x, input int y);
        vec_t v = vi;
        v.ex[j*10 +: 10] = 10'(x);
        v.ey[j*10 +: 10] = 10'(y);
        v.ea[j] = 1'b1;
        return v;
    endfunction

    task automatic add_row(input vec_t vi, input logic [7:0] bh, input logic [7:0] eh,
                           input int lat, input string name);
        vec_t v = vi;
        v.bh = bh; v.eh = eh; v.lat = lat; v.name = name;
        rows.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        bullet_x_bus  = v.bx;
        bullet_y_bus  = v.by;
        bullet_active = v.ba;
        enemy_x_bus   = v.ex;
        enemy_y_bus   = v.ey;
        enemy_alive   = v.ea;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(negedge clk25);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge where hit_valid is seen (or the budget ran out).
    task automatic start_and_wait(input string name, output int lat, output bit got);
        frame_start = 1'b1;
        @(negedge clk25);
        frame_start = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        got = 1'b0;
        while (!got && lat < 300) begin
            if (hit_valid) got = 1'b1;
            else begin
                @(negedge clk25);
                lat++;
            end
        end
    endtask

    int   lat;
    bit   got;
    int   pulses;
    vec_t v;
`ifdef SCORE_COUNTER_EN
    int   exp_score;
`endif

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        apply(blank());

        v = blank(); v = set_b(v, 0, 100, 100); v.ba[0] = 1'b0; v = set_e(v, 3, 90, 80);
        add_row(v, 8'h00, 8'h00, 66, "no_active");
        v = blank(); v = set_b(v, 0, 100, 100); v = set_e(v, 3, 90, 80);
        add_row(v, 8'h01, 8'h08, 62, "b0_e3");
        v = blank(); v = set_b(v, 0, 100, 100); v = set_b(v, 1, 100, 100); v = set_e(v, 2, 90, 80);
        add_row(v, 8'h01, 8'h04, 61, "two_on_e2");
        v = blank(); v = set_b(v, 0, 122, 100); v = set_e(v, 3, 90, 80);
        add_row(v, 8'h00, 8'h00, 66, "x_touch_right");
        v = blank(); v = set_b(v, 0, 121, 100); v = set_e(v, 3, 90, 80);
        add_row(v, 8'h01, 8'h08, 62, "x_overlap_right");
        v = blank(); v = set_b(v, 0, 82, 100); v = set_e(v, 3, 90, 80);
        add_row(v, 8'h00, 8'h00, 66, "x_touch_left");
        v = blank(); v = set_b(v, 0, 100, 72); v = set_e(v, 3, 90, 80);
        add_row(v, 8'h00, 8'h00, 66, "y_touch_top");
        v = blank(); v = set_b(v, 0, 100, 73); v = set_e(v, 3, 90, 80);
        add_row(v, 8'h01, 8'h08, 62, "y_overlap_top");
        v = blank(); v = set_b(v, 0, 100, 112); v = set_e(v, 3, 90, 80);
        add_row(v, 8'h00, 8'h00, 66, "y_touch_bottom");
        v = blank(); v = set_b(v, 0, 1010, 1000); v = set_e(v, 0, 1000, 1000);
        add_row(v, 8'h01, 8'h01, 59, "no_wrap_1023");
        v = blank(); v = set_b(v, 0, 100, 100); v = set_e(v, 3, 90, 80); v.ea[3] = 1'b0;
        add_row(v, 8'h00, 8'h00, 66, "dead_enemy");
        v = blank(); v = set_b(v, 2, 215, 210); v = set_b(v, 5, 230, 210);
        v = set_e(v, 1, 200, 200); v = set_e(v, 5, 210, 200);
        add_row(v, 8'h24, 8'h22, 58, "lowest_index");
        v = blank(); v = set_b(v, 0, 105, 305); v = set_b(v, 1, 305, 305); v = set_b(v, 2, 505, 305);
        v = set_e(v, 0, 100, 300); v = set_e(v, 1, 300, 300); v = set_e(v, 2, 500, 300);
        add_row(v, 8'h07, 8'h07, 48, "three_kills");

        do_reset();
        check("rst_hit_valid", 32'(hit_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_bullet_hit", 32'(bullet_hit), 32'd0);
        check("rst_enemy_hit", 32'(enemy_hit), 32'd0);
`ifdef SCORE_COUNTER_EN
        check("rst_score", 32'(score), 32'd0);
        exp_score = 0;
`endif

        foreach (rows[k]) begin
            apply(rows[k]);
            start_and_wait(rows[k].name, lat, got);
            check({rows[k].name, "_valid"}, 32'(got), 32'd1);
            check({rows[k].name, "_latency"}, 32'(lat), 32'(rows[k].lat));
            check({rows[k].name, "_bullet_hit"}, 32'(bullet_hit), 32'(rows[k].bh));
            check({rows[k].name, "_enemy_hit"}, 32'(enemy_hit), 32'(rows[k].eh));
            @(negedge clk25);
            check({rows[k].name, "_valid_pulse"}, 32'(hit_valid), 32'd0);
            check({rows[k].name, "_masks_idle"}, 32'({bullet_hit, enemy_hit}), 32'd0);
            check({rows[k].name, "_idle"}, 32'(busy), 32'd0);
`ifdef SCORE_COUNTER_EN
            exp_score += $countones(rows[k].eh);
            check({rows[k].name, "_score"}, 32'(score), 32'(exp_score));
`endif
        end
        check("no_overrun_after_table", 32'(overrun), 32'd0);

        // Inputs altered mid-scan must not change the snapshot result.
        apply(rows[1]);
        frame_start = 1'b1;
        @(negedge clk25);
        frame_start = 1'b0;
        repeat (5) @(negedge clk25);
        bullet_active = '0;
        enemy_alive   = '0;
        bullet_x_bus  = '0;
        lat = 6; got = 1'b0;
        while (!got && lat < 300) begin
            if (hit_valid) got = 1'b1;
            else begin @(negedge clk25); lat++; end
        end
        check("mid_scan_change_valid", 32'(got), 32'd1);
        check("mid_scan_change_latency", 32'(lat), 32'd62);
        check("mid_scan_change_masks", 32'({bullet_hit, enemy_hit}), 32'h0108);
        @(negedge clk25);

        // frame_start landing on the REPORT cycle is dropped and flagged.
        apply(rows[0]);
        start_and_wait("report_collide", lat, got);
        check("report_collide_valid", 32'(got), 32'd1);
        frame_start = 1'b1;
        @(negedge clk25);
        frame_start = 1'b0;
        check("report_collide_busy", 32'(busy), 32'd0);
        check("report_collide_overrun", 32'(overrun), 32'd1);
        repeat (3) @(negedge clk25);
        check("report_collide_no_restart", 32'(busy), 32'd0);

        // Second frame_start 10 cycles into a scan: one result, overrun set.
        do_reset();
        check("reset_clears_overrun", 32'(overrun), 32'd0);
        apply(rows[1]);
        frame_start = 1'b1;
        @(negedge clk25);
        frame_start = 1'b0;
        repeat (9) @(negedge clk25);
        frame_start = 1'b1;
        @(negedge clk25);
        frame_start = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        pulses = 0;
        for (int c = 0; c < 150; c++) begin
            if (hit_valid) begin
                pulses++;
                check("overrun_masks", 32'({bullet_hit, enemy_hit}), 32'h0108);
            end
            @(negedge clk25);
        end
        check("overrun_single_valid", 32'(pulses), 32'd1);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset mid-scan aborts without a result.
        frame_start = 1'b1;
        @(negedge clk25);
        frame_start = 1'b0;
        repeat (20) @(negedge clk25);
        rst_n = 1'b0;
        @(negedge clk25);
        rst_n = 1'b1;
        check("abort_overrun", 32'(overrun), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int c = 0; c < 100; c++) begin
            if (hit_valid) pulses++;
            @(negedge clk25);
        end
        check("abort_no_valid", 32'(pulses), 32'd0);

`ifdef SCORE_COUNTER_EN
        do_reset();
        for (int f = 0; f < 2; f++) begin
            apply(rows[12]);
            start_and_wait("score_frame", lat, got);
            check("score_frame_valid", 32'(got), 32'd1);
            @(negedge clk25);
        end
        check("score_two_frames", 32'(score), 32'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
